// File: rtl/instruction_fetch_queue_if.sv
// ============================================================================
// Module : instruction_fetch_queue_if
// Brief  : Memory-port, redirect and decode-handshake bundle of the fetch queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_queue_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_rsp_valid;
   logic [INST_W-1:0] mem_rsp_data;
   logic              mem_rsp_fault;
   logic              override_pc;
   logic [ADDR_W-1:0] override_pc_addr;
   logic              valid;
   logic              ready;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              exception_valid;
   logic [5:0]        exception_num;

   modport master (
      output mem_req_valid, mem_req_addr, valid, inst, inst_pc,
             exception_valid, exception_num,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_fault,
             override_pc, override_pc_addr, ready
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, valid, inst, inst_pc,
             exception_valid, exception_num,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_fault,
             override_pc, override_pc_addr, ready
   );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
// ============================================================================
// Module : instruction_fetch_queue
// Brief  : Pipelined in-order instruction fetch with prefetch queue and redirect.
//          Optional perf counters enabled by defining IFQ_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch_queue #(
   parameter int              ADDR_W          = 32,
   parameter int              INST_W          = 32,
   parameter int              QUEUE_DEPTH     = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [ADDR_W-1:0] RESET_ADDR    = '0
) (
   input  logic clk,
   input  logic reset_n,
   instruction_fetch_queue_if.master bus
`ifdef IFQ_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_dropped
`endif
);
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int SUM_W = CNT_W + 1;
   localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(QUEUE_DEPTH);
   localparam logic [SUM_W-1:0]  C_DEPTH_SUM = SUM_W'(QUEUE_DEPTH);
   localparam logic [PTR_W-1:0]  C_LAST      = PTR_W'(QUEUE_DEPTH - 1);
   localparam logic [OUT_W-1:0]  C_MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
   localparam logic [INST_W-1:0] C_IDLE_INST = INST_W'(32'h000C_0DE0);
   localparam logic [INST_W-1:0] C_EXC_INST  = INST_W'(32'h001C_0DE0);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [OUT_W-1:0]  outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
   logic              halt_q, halt_d;
   logic [ADDR_W-1:0] pc_mem_q   [QUEUE_DEPTH];
   logic [ADDR_W-1:0] pc_mem_d   [QUEUE_DEPTH];
   logic [INST_W-1:0] inst_mem_q [QUEUE_DEPTH];
   logic [INST_W-1:0] inst_mem_d [QUEUE_DEPTH];
   logic              exc_mem_q  [QUEUE_DEPTH];
   logic              exc_mem_d  [QUEUE_DEPTH];
   logic              num_mem_q  [QUEUE_DEPTH];
   logic              num_mem_d  [QUEUE_DEPTH];

   logic [SUM_W-1:0]  w_inflight;
   logic              w_aligned, w_issue, w_req_fire, w_drop, w_rsp_push;
   logic              w_exc_push, w_push, w_pop, w_valid;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == C_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit check counts in-flight requests against free queue slots so every
   // response is guaranteed a place without back-pressuring memory.
   assign w_inflight = {{(SUM_W-OUT_W){1'b0}}, outstanding_q} + {1'b0, count_q};
   assign w_aligned  = (fetch_pc_q[1:0] == 2'b00);
   assign w_issue    = reset_n & ~bus.override_pc & ~halt_q & w_aligned
                     & (outstanding_q < C_MAX_OUT) & (w_inflight < C_DEPTH_SUM);
   assign w_req_fire = w_issue & bus.mem_req_ready;
   assign w_drop     = bus.mem_rsp_valid & (bus.override_pc | (drop_cnt_q != '0));
   assign w_rsp_push = bus.mem_rsp_valid & ~w_drop;
   assign w_exc_push = ~bus.override_pc & ~halt_q & ~w_aligned
                     & (outstanding_q == '0) & (count_q < C_DEPTH);
   assign w_push     = w_rsp_push | w_exc_push;
   assign w_valid    = (count_q != '0);
   assign w_pop      = w_valid & bus.ready & ~bus.override_pc;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      halt_d        = halt_q;
      pc_mem_d      = pc_mem_q;
      inst_mem_d    = inst_mem_q;
      exc_mem_d     = exc_mem_q;
      num_mem_d     = num_mem_q;

      if (w_req_fire && !bus.mem_rsp_valid)
         outstanding_d = outstanding_q + OUT_W'(1);
      else if (!w_req_fire && bus.mem_rsp_valid)
         outstanding_d = outstanding_q - OUT_W'(1);

      if (bus.override_pc) begin
         drop_cnt_d = outstanding_q - OUT_W'(bus.mem_rsp_valid);
         fetch_pc_d = bus.override_pc_addr;
         rsp_pc_d   = bus.override_pc_addr;
         halt_d     = 1'b0;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (w_drop)
            drop_cnt_d = drop_cnt_q - OUT_W'(1);
         if (w_req_fire)
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
         if (w_rsp_push)
            rsp_pc_d = rsp_pc_q + ADDR_W'(4);
         if (w_exc_push)
            halt_d = 1'b1;
         if (w_push) begin
            pc_mem_d[tail_q]   = w_rsp_push ? rsp_pc_q : fetch_pc_q;
            inst_mem_d[tail_q] = (w_rsp_push && !bus.mem_rsp_fault) ? bus.mem_rsp_data
                                                                     : C_EXC_INST;
            exc_mem_d[tail_q]  = w_rsp_push ? bus.mem_rsp_fault : 1'b1;
            num_mem_d[tail_q]  = w_rsp_push;
            tail_d             = ptr_inc(tail_q);
         end
         if (w_pop)
            head_d = ptr_inc(head_q);
         if (w_push && !w_pop)
            count_d = count_q + CNT_W'(1);
         else if (!w_push && w_pop)
            count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q    <= RESET_ADDR;
         rsp_pc_q      <= RESET_ADDR;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         halt_q        <= 1'b0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
            exc_mem_q[i]  <= 1'b0;
            num_mem_q[i]  <= 1'b0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         halt_q        <= halt_d;
         pc_mem_q      <= pc_mem_d;
         inst_mem_q    <= inst_mem_d;
         exc_mem_q     <= exc_mem_d;
         num_mem_q     <= num_mem_d;
      end
   end

   assign bus.mem_req_valid   = w_issue;
   assign bus.mem_req_addr    = fetch_pc_q;
   assign bus.valid           = w_valid;
   assign bus.inst            = w_valid ? inst_mem_q[head_q] : C_IDLE_INST;
   assign bus.inst_pc         = w_valid ? pc_mem_q[head_q] : '0;
   assign bus.exception_valid = w_valid & exc_mem_q[head_q];
   assign bus.exception_num   = w_valid ? {5'b0, num_mem_q[head_q]} : 6'd0;

`ifdef IFQ_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d, perf_dropped_q, perf_dropped_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q + {31'b0, w_pop};
      perf_dropped_d = perf_dropped_q + {31'b0, w_drop};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched_q <= '0;
         perf_dropped_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_dropped_q <= perf_dropped_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_dropped = perf_dropped_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
// ============================================================================
// Module : tb_instruction_fetch_queue
// Brief  : Directed self-checking bench for instruction_fetch_queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_queue;
   localparam logic [31:0] C_IDLE_INST = 32'h000C_0DE0;
   localparam logic [31:0] C_EXC_INST  = 32'h001C_0DE0;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int          mem_lat    = 1;
   logic [31:0] fault_addr = 32'hFFFF_FFFF;
   int          req_count  = 0;
   int          cyc        = 0;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } pend_t;
   pend_t pend_q[$];

   always #5 clk = ~clk;

   instruction_fetch_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

`ifdef IFQ_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_dropped;
`endif

   instruction_fetch_queue #(
      .ADDR_W(32), .INST_W(32), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2),
      .RESET_ADDR(32'h0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
`ifdef IFQ_PERF_CNT_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_dropped(perf_dropped)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hCAFE_0000;
   endfunction

   // In-order memory: accepted requests answered mem_lat cycles later.
   initial begin
      pend_t p;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      bus.mem_rsp_fault = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         if (!reset_n) begin
            pend_q.delete();
            #1 bus.mem_rsp_valid = 1'b0;
         end else begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
               pend_q.push_back('{cyc + mem_lat - 1, bus.mem_req_addr});
               req_count++;
            end
            #1;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
               p = pend_q.pop_front();
               bus.mem_rsp_valid = 1'b1;
               bus.mem_rsp_data  = mem_word(p.addr);
               bus.mem_rsp_fault = (p.addr == fault_addr);
            end else begin
               bus.mem_rsp_valid = 1'b0;
               bus.mem_rsp_fault = 1'b0;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n              = 1'b0;
      bus.ready            = 1'b0;
      bus.override_pc      = 1'b0;
      bus.override_pc_addr = '0;
      bus.mem_req_ready    = 1'b1;
      fault_addr           = 32'hFFFF_FFFF;
      mem_lat              = 1;
      repeat (2) @(negedge clk);
      req_count = 0;
      reset_n   = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.mem_req_valid !== 1'b0 || bus.valid !== 1'b0 || bus.exception_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: req_valid=%b valid=%b exc=%b, expected 0 0 0",
                  bus.mem_req_valid, bus.valid, bus.exception_valid);
      end
      checks++;
      if (bus.inst !== C_IDLE_INST || bus.inst_pc !== 32'h0 || bus.exception_num !== 6'd0) begin
         errors++;
         $display("FAIL reset_data: inst=%h pc=%h num=%0d, expected %h 0 0",
                  bus.inst, bus.inst_pc, bus.exception_num, C_IDLE_INST);
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      do_reset();
      bus.ready = 1'b1;
      exp = 32'h0;
      @(negedge clk);
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_fill: valid=%b, expected 0", bus.valid);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (bus.valid !== 1'b1 || bus.inst_pc !== exp || bus.inst !== mem_word(exp)) begin
            errors++;
            $display("FAIL stream_%0d: valid=%b pc=%h inst=%h, expected 1 %h %h",
                     i, bus.valid, bus.inst_pc, bus.inst, exp, mem_word(exp));
         end
         exp += 4;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp;
      do_reset();
      repeat (10) @(negedge clk);
      checks++;
      if (req_count !== 4 || bus.mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_credit: requests=%0d req_valid=%b, expected 4 0",
                  req_count, bus.mem_req_valid);
      end
      exp = 32'h0;
      bus.ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (bus.valid !== 1'b1 || bus.inst_pc !== exp || bus.inst !== mem_word(exp)) begin
            errors++;
            $display("FAIL bp_drain_%0d: valid=%b pc=%h, expected 1 %h",
                     i, bus.valid, bus.inst_pc, exp);
         end
         @(negedge clk);
         exp += 4;
      end
   endtask

   task automatic test_redirect();
      bit seen;
      do_reset();
      mem_lat = 3;
      repeat (2) @(negedge clk);
      bus.override_pc      = 1'b1;
      bus.override_pc_addr = 32'h100;
      #1;
      checks++;
      if (req_count !== 2 || bus.mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_setup: requests=%0d req_valid=%b, expected 2 0",
                  req_count, bus.mem_req_valid);
      end
      @(negedge clk);
      bus.override_pc = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus.valid;
      end
      checks++;
      if (!seen || bus.inst_pc !== 32'h100 || bus.inst !== mem_word(32'h100)) begin
         errors++;
         $display("FAIL redir_target: seen=%b pc=%h inst=%h, expected 1 00000100 %h",
                  seen, bus.inst_pc, bus.inst, mem_word(32'h100));
      end
`ifdef IFQ_PERF_CNT_EN
      checks++;
      if (perf_dropped !== 32'd2) begin
         errors++;
         $display("FAIL perf_dropped: got %0d, expected 2", perf_dropped);
      end
`endif
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.ready = 1'b1;
      repeat (4) @(negedge clk);
      bus.override_pc      = 1'b1;
      bus.override_pc_addr = 32'h200;
      #1;
      checks++;
      if (bus.mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_req: req_valid=%b, expected 0", bus.mem_req_valid);
      end
      @(negedge clk);
      bus.override_pc_addr = 32'h300;
      @(negedge clk);
      bus.override_pc = 1'b0;
      #1;
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h300 || bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_req: req_valid=%b addr=%h valid=%b, expected 1 00000300 0",
                  bus.mem_req_valid, bus.mem_req_addr, bus.valid);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.valid !== 1'b1 || bus.inst_pc !== 32'h300) begin
         errors++;
         $display("FAIL b2b_head: valid=%b pc=%h, expected 1 00000300", bus.valid, bus.inst_pc);
      end
   endtask

   task automatic test_misalign();
      do_reset();
      bus.override_pc      = 1'b1;
      bus.override_pc_addr = 32'h102;
      @(negedge clk);
      bus.override_pc = 1'b0;
      #1;
      checks++;
      if (bus.mem_req_valid !== 1'b0 || bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL mis_no_req: req_valid=%b valid=%b, expected 0 0",
                  bus.mem_req_valid, bus.valid);
      end
      @(negedge clk);
      checks++;
      if (bus.valid !== 1'b1 || bus.inst_pc !== 32'h102 || bus.exception_valid !== 1'b1
          || bus.exception_num !== 6'd0 || bus.inst !== C_EXC_INST) begin
         errors++;
         $display("FAIL mis_entry: valid=%b pc=%h exc=%b num=%0d inst=%h, expected 1 00000102 1 0 %h",
                  bus.valid, bus.inst_pc, bus.exception_valid, bus.exception_num, bus.inst,
                  C_EXC_INST);
      end
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || req_count !== 0) begin
         errors++;
         $display("FAIL mis_halt: valid=%b req_valid=%b requests=%0d, expected 0 0 0",
                  bus.valid, bus.mem_req_valid, req_count);
      end
      bus.override_pc      = 1'b1;
      bus.override_pc_addr = 32'h40;
      @(negedge clk);
      bus.override_pc = 1'b0;
      #1;
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h40) begin
         errors++;
         $display("FAIL mis_resume: req_valid=%b addr=%h, expected 1 00000040",
                  bus.mem_req_valid, bus.mem_req_addr);
      end
   endtask

   task automatic test_fault();
      do_reset();
      fault_addr = 32'h8;
      bus.ready  = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.exception_valid !== 1'b0) begin
         errors++;
         $display("FAIL fault_clean: valid=%b pc=%h exc=%b, expected 1 0 0",
                  bus.valid, bus.inst_pc, bus.exception_valid);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.valid !== 1'b1 || bus.inst_pc !== 32'h8 || bus.exception_valid !== 1'b1
          || bus.exception_num !== 6'd1 || bus.inst !== C_EXC_INST) begin
         errors++;
         $display("FAIL fault_entry: valid=%b pc=%h exc=%b num=%0d inst=%h, expected 1 00000008 1 1 %h",
                  bus.valid, bus.inst_pc, bus.exception_valid, bus.exception_num, bus.inst,
                  C_EXC_INST);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.ready = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.inst !== C_IDLE_INST
          || bus.inst_pc !== 32'h0 || bus.exception_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_out: valid=%b req_valid=%b inst=%h pc=%h exc=%b, expected 0 0 %h 0 0",
                  bus.valid, bus.mem_req_valid, bus.inst, bus.inst_pc, bus.exception_valid,
                  C_IDLE_INST);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_req: req_valid=%b addr=%h, expected 1 0",
                  bus.mem_req_valid, bus.mem_req_addr);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== mem_word(32'h0)) begin
         errors++;
         $display("FAIL rstmid_head: valid=%b pc=%h, expected 1 0", bus.valid, bus.inst_pc);
      end
   endtask

   initial begin
      bus.ready            = 1'b0;
      bus.override_pc      = 1'b0;
      bus.override_pc_addr = '0;
      bus.mem_req_ready    = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_back_to_back();
      test_misalign();
      test_fault();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
